imem_fetch_port: RTL
====================

Name: imem_fetch_port

Overview:
- Parametrised, clocked successor to the combinational instruction memory.
- Accepts 64-bit byte-addressed PC fetch requests over a valid/ready handshake. Reads a synchronous word array and returns instructions, in order, through an output buffer that absorbs backpressure.
- Adds a program-load write port and fault reporting for misaligned and out-of-range PCs.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- ADDR_W, 64, PC / byte-address width.
- DATA_W, 32, instruction word width; must be 32 for the ARM core.
- DEPTH_LOG2, 10, log2 of the number of words in the array (1024 words by default).
- OUT_DEPTH, 2, number of output-buffer entries; must be at least 1; 2 or more gives full throughput under backpressure.
- NOP_WORD, 32'hD503201F, instruction returned on a faulted fetch.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- req_valid  in  1  fetch request is valid.
- req_ready  out  1  block can accept a request this cycle.
- req_pc  in  ADDR_W  byte address to fetch.
- resp_valid  out  1  head of the output buffer is valid.
- resp_ready  in  1  consumer takes the head this cycle.
- resp_instr  out  DATA_W  fetched instruction, or NOP_WORD on a fault.
- resp_pc  out  ADDR_W  PC that produced this response.
- resp_err  out  2  fault code: 00 none, 01 misaligned, 10 out of range, 11 parity (feature only).
- ld_en  in  1  program-load write strobe.
- ld_addr  in  DEPTH_LOG2  word index to write.
- ld_data  in  DATA_W  word to write.
- occupancy  out  clog2(OUT_DEPTH+1)  number of valid buffer entries.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Buffer pointers and occupancy clear; resp_valid=0, req_ready=0 during reset.
  - resp_instr, resp_pc and resp_err read 0 while the buffer is empty.
  - The memory array is NOT cleared.
  - A request accepted in the cycle before reset is dropped.
- Handshake:
  - A request is accepted when req_valid && req_ready at the rising edge.
  - A response is consumed when resp_valid && resp_ready.
  - req_ready = (occupancy < OUT_DEPTH) and out of reset. It is registered-state only, with no combinational path from resp_ready.
- Latency:
  - A request accepted at the edge ending cycle N performs a synchronous array read and pushes {instr, pc, err} into the buffer at that same edge.
  - resp_valid is high in cycle N+1. This fixed 1-cycle latency is the minimum.
- Ordering and stalling:
  - Responses leave strictly in request order.
  - Head outputs hold stable while resp_valid && !resp_ready.
- Simultaneous push and pop: occupancy is unchanged. This is legal when full, but req_ready is already low in that case, so no push occurs when full.
- Index and fault checks:
  - Word index = req_pc[DEPTH_LOG2+1:2].
  - Misaligned: req_pc[1:0] != 0 gives err=01 and instr=NOP_WORD; the array is not read.
  - Out of range: any of req_pc[ADDR_W-1:DEPTH_LOG2+2] is set, giving err=10 and instr=NOP_WORD.
  - If both faults apply, misaligned wins.
- Load port:
  - ld_en writes ld_data to mem[ld_addr] at the edge; the write is independent of the handshake.
  - A same-cycle read of the same index returns the OLD word (read-before-write).
  - Writes are honoured during reset.
- Buffer pointers wrap modulo OUT_DEPTH, and OUT_DEPTH need not be a power of 2.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each array word stores an extra even-parity bit, computed on load-port writes.
  - A fetch whose stored parity mismatches returns err=11 and instr=NOP_WORD.
  - A single-bit input, inj_par_err, exists; when it is high with ld_en, the stored parity bit is inverted.
- Undefined:
  - There is no parity storage and no inj_par_err port.
  - Code 11 is never produced.

Decomposition:
- Shared package imem_pkg holds:
  - fault-code constants ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_PARITY;
  - the NOP_WORD constant;
  - the response struct typedef {instr, pc, err}.
- Sub-module resp_fifo: generic OUT_DEPTH-entry synchronous FIFO carrying the response struct and exposing occupancy.
- The array and fault decode stay in the top level.

Test Plan:
- Reset, load, back-to-back fetch: load mem[0..3] = 8b1f03e5, f84000a4, 8b040086, f80010a6; fetch PCs 0, 4, 8, 12 on consecutive cycles with resp_ready=1 -> four responses in cycles N+1..N+4 with matching instr/pc and err=00.
- Backpressure: hold resp_ready=0 with OUT_DEPTH=2 -> req_ready drops after 2 accepts; head holds at pc=0; releasing resp_ready drains in order with no loss or duplication.
- Misaligned fetch: PC=0x6 -> err=01, instr=D503201F. Fetch PC=0x1_0000_0000 -> err=10, instr=D503201F.
- Read-during-write: ld_en writes mem[5]=DEADBEEF while PC=0x14 is fetched in the same cycle -> the old word is returned; the next fetch of 0x14 returns DEADBEEF.
- Reset mid-stream: assert rst_n=0 with 2 entries buffered and one request in flight -> resp_valid=0 and occupancy=0 next cycle; mem contents are preserved across reset.
- With IMEM_PARITY_EN: load mem[2] with inj_par_err=1, then fetch PC=8 -> err=11, instr=D503201F.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch port:
//   - fault codes carried on resp_err
//   - the NOP instruction returned on a faulted fetch
//   - resp_t, the {instr, pc, err} record held in the output buffer
// The struct is sized for the ARM core (32-bit instructions, 64-bit PCs).
// Optional feature macro used by the top level: IMEM_PARITY_EN.
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int PKG_ADDR_W = 64;
    localparam int PKG_DATA_W = 32;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_PARITY   = 2'b11;

    localparam logic [PKG_DATA_W-1:0] NOP_WORD = 32'hD503201F;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] instr;
        logic [PKG_ADDR_W-1:0] pc;
        logic [1:0]            err;
    } resp_t;

    // Even-parity bit: makes the total number of ones in {word, bit} even.
    function automatic logic even_parity(input logic [PKG_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_fetch_port_resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Generic DEPTH-entry synchronous FIFO of resp_t records with an occupancy
// count. DEPTH need not be a power of two; pointers wrap explicitly.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears pointers/count)
//   i_push, i_data  write a record at the rising edge (ignored when full)
//   i_pop           drop the head record at the rising edge (ignored when empty)
//   o_head          head record, all zeros while empty
//   o_count         number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module resp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  resp_t            i_data,
    input  logic             i_pop,
    output resp_t            o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_t             r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop  && (r_count != '0);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            // Push and pop together leave the count unchanged.
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_port.sv
// -----------------------------------------------------------------------------
// imem_fetch_port
// Clocked instruction memory between the IF-stage PC register and the IF/ID
// register. PC fetch requests are accepted over valid/ready, the word array is
// read at the accepting edge and the {instr, pc, err} record goes straight into
// an OUT_DEPTH-entry output buffer, so a response is visible one cycle after
// acceptance and responses leave in request order.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. Head
// outputs hold while resp_valid && !resp_ready. req_ready depends only on
// registered occupancy and rst_n, never on resp_ready.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready/req_pc      fetch request (byte address)
//   resp_valid/resp_ready           response handshake
//   resp_instr/resp_pc/resp_err     head of output buffer (zeros when empty)
//   ld_en/ld_addr/ld_data           program-load write port (works in reset)
//   inj_par_err                     only with IMEM_PARITY_EN: flip stored parity
//   occupancy                       valid entries in the output buffer
//
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, fault code 11).
// -----------------------------------------------------------------------------
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                OUT_DEPTH  = 2,
    parameter logic [DATA_W-1:0] NOP_WORD   = imem_pkg::NOP_WORD
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_pc,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [DATA_W-1:0]               resp_instr,
    output logic [ADDR_W-1:0]               resp_pc,
    output logic [1:0]                      resp_err,
    input  logic                            ld_en,
    input  logic [DEPTH_LOG2-1:0]           ld_addr,
    input  logic [DATA_W-1:0]               ld_data,
`ifdef IMEM_PARITY_EN
    input  logic                            inj_par_err,
`endif
    output logic [$clog2(OUT_DEPTH+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int WORDS = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [WORDS];
`ifdef IMEM_PARITY_EN
    logic                  r_par [WORDS];
`endif

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_misalign;
    logic                  w_range;
    logic                  w_accept;
    logic                  w_pop;
    resp_t                 w_resp;
    resp_t                 w_head;
    logic [OCC_W-1:0]      w_occ;

    // ---------------------------------------------------------------- array
    // Read is combinational into the buffer's write port, so the array read
    // and the buffer push happen at the same edge. The load write uses <=,
    // so a same-edge fetch of the written index sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
            r_par[ld_addr] <= even_parity(ld_data) ^ inj_par_err;
`endif
        end
    end

    assign w_idx     = req_pc[DEPTH_LOG2+1:2];
    assign w_rd_word = r_mem[w_idx];

    // ---------------------------------------------------------- fault decode
    assign w_misalign = |req_pc[1:0];
    assign w_range    = |req_pc[ADDR_W-1:DEPTH_LOG2+2];

    // Priority: misaligned, then out of range, then parity.
    always_comb begin
        w_resp       = '0;
        w_resp.pc    = req_pc;
        w_resp.instr = w_rd_word;
        w_resp.err   = ERR_NONE;
        if (w_misalign) begin
            w_resp.instr = NOP_WORD;
            w_resp.err   = ERR_MISALIGN;
        end else if (w_range) begin
            w_resp.instr = NOP_WORD;
            w_resp.err   = ERR_RANGE;
        end
`ifdef IMEM_PARITY_EN
        else if (even_parity(w_rd_word) != r_par[w_idx]) begin
            w_resp.instr = NOP_WORD;
            w_resp.err   = ERR_PARITY;
        end
`endif
    end

    // ------------------------------------------------------------ handshake
    assign req_ready  = rst_n && (w_occ < OCC_W'(OUT_DEPTH));
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (w_occ != '0);
    assign w_pop      = resp_valid && resp_ready;

    resp_fifo #(
        .DEPTH (OUT_DEPTH),
        .CNT_W (OCC_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_resp),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_occ)
    );

    assign resp_instr = w_head.instr;
    assign resp_pc    = w_head.pc;
    assign resp_err   = w_head.err;
    assign occupancy  = w_occ;

endmodule
